// File: rtl/speed_display.sv
// Samples the speed word, converts it to BCD and multiplexes it onto a 4-digit seven-segment display.
// Latency: sample at S, bcd/bcd_valid visible at S+16, display follows one register stage later.
// Backpressure: none; a sample arriving while a conversion is in flight is dropped.
module speed_display #(
    parameter int CLK_HZ         = 50000000,
    parameter int UPDATE_HZ      = 4,
    parameter int SCAN_HZ        = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_50Mhz,
    input  logic        rst,
    input  logic [13:0] speed_in,
    output logic [7:0]  seg,
    output logic [3:0]  digit_sel,
    output logic [15:0] bcd,
    output logic        bcd_valid
);

    localparam int UPDATE_DIV = CLK_HZ / UPDATE_HZ;
    localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
    localparam int UPD_W      = $clog2(UPDATE_DIV);
    localparam int SCAN_W     = $clog2(SCAN_DIV);
    localparam logic [UPD_W-1:0]  UPD_MAX  = UPD_W'(UPDATE_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t             state;
    logic [29:0]        shreg;
    logic [29:0]        adj;
    logic [3:0]         iter;
    logic [13:0]        clamped;
    logic [UPD_W-1:0]   upd_cnt;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         dig_idx;
    logic [3:0]         lz;
    logic [3:0]         nib;
    logic [6:0]         seg_raw;

    assign clamped = (speed_in >= 14'd10000) ? 14'd9999 : speed_in;

    always_comb begin
        adj = shreg;
        for (int i = 0; i < 4; i++) begin
            if (shreg[14 + 4*i +: 4] >= 4'd5)
                adj[14 + 4*i +: 4] = shreg[14 + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            iter      <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (upd_cnt == '0) begin
                        shreg <= {16'd0, clamped};
                        iter  <= '0;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    shreg <= adj << 1;
                    iter  <= iter + 4'd1;
                    if (iter == 4'd13)
                        state <= LOAD;
                end
                LOAD: begin
                    bcd       <= shreg[29:14];
                    bcd_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            upd_cnt  <= '0;
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else begin
            upd_cnt <= (upd_cnt == UPD_MAX) ? '0 : upd_cnt + 1'b1;
            if (scan_cnt == SCAN_MAX) begin
                scan_cnt <= '0;
                dig_idx  <= dig_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // lz[k]: this digit and every more significant digit are zero, so it is a leading zero.
    always_comb begin
        lz[3] = (bcd[15:12] == 4'd0);
        lz[2] = lz[3] && (bcd[11:8] == 4'd0);
        lz[1] = lz[2] && (bcd[7:4] == 4'd0);
        lz[0] = 1'b0;
        nib   = bcd[dig_idx*4 +: 4];
        case (nib)
            4'd0:    seg_raw = 7'h3F;
            4'd1:    seg_raw = 7'h06;
            4'd2:    seg_raw = 7'h5B;
            4'd3:    seg_raw = 7'h4F;
            4'd4:    seg_raw = 7'h66;
            4'd5:    seg_raw = 7'h6D;
            4'd6:    seg_raw = 7'h7D;
            4'd7:    seg_raw = 7'h07;
            4'd8:    seg_raw = 7'h7F;
            4'd9:    seg_raw = 7'h6F;
            default: seg_raw = 7'h00;
        endcase
        if (lz[dig_idx])
            seg_raw = 7'h00;
    end

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            seg       <= SEG_OFF;
            digit_sel <= DIG_OFF;
        end else begin
            seg       <= {1'b0, seg_raw} ^ SEG_OFF;
            digit_sel <= (4'b0001 << dig_idx) ^ DIG_OFF;
        end
    end

endmodule

// File: doc/speed_display.md
# speed_display

Display stage downstream of the wheel speed meter. Samples the 14-bit cm/s speed word at a fixed update rate, clamps it to four decimal digits, converts it to BCD with a sequential shift-add-3 engine, and drives a 4-digit multiplexed seven-segment display with leading-zero blanking. The BCD result is also exported for test and for other consumers.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- UPDATE_HZ, 4, speed sampling rate in Hz; UPDATE_DIV = CLK_HZ/UPDATE_HZ, integer, ≥ 32
- SCAN_HZ, 1000, digit advance rate in Hz; SCAN_DIV = CLK_HZ/SCAN_HZ, integer, ≥ 2
- SEG_ACTIVE_LOW, 1, 1: segment lit = 0
- DIG_ACTIVE_LOW, 1, 1: digit enabled = 0
- clk_50Mhz  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- speed_in  in  14  speed in cm/s from the speed meter, unsigned
- seg  out  8  {dp,g,f,e,d,c,b,a}, registered
- digit_sel  out  4  one-hot digit enable; bit0 = units (rightmost), registered
- bcd  out  16  {thousands,hundreds,tens,units} of the last completed conversion
- bcd_valid  out  1  one-cycle pulse when bcd updates

## Operation
- Update counter upd_cnt: 0..UPDATE_DIV-1, increments every cycle, wraps to 0.
- A sample occurs on any cycle with upd_cnt==0 and FSM in IDLE. A sample while the FSM is not IDLE is dropped, not queued.
- Clamp: speed_in ≥ 10000 → 9999; otherwise unchanged.
- FSM states:
  - IDLE → CONVERT on sample. Load the shift register with {16'd0, clamped value}, 30 bits total. Set iteration count to 0.
  - CONVERT: one iteration per cycle. Add 3 to each BCD nibble ≥ 5, then shift the whole register left by 1. Stays for exactly 14 cycles, then → LOAD.
  - LOAD: copy the BCD nibbles to bcd, assert bcd_valid for that one cycle, → IDLE.
- Scan counter: 0..SCAN_DIV-1. On wrap, digit index 0→1→2→3→0.
- Each cycle, register digit_sel and seg from the current index and the current bcd.
- Segment map, active-high before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - dp always off
  - nibbles A–F unreachable; drive blank
- Leading-zero blanking:
  - Digit k is blank (all segments off) if k>0 and all nibbles k..3 are zero.
  - Units digit is never blanked.
- Polarity parameters invert seg and digit_sel at the output register only.

## Timing
- Reset values:
  - bcd=0, bcd_valid=0, FSM=IDLE, upd_cnt=0, scan counter=0, digit index=0
  - seg = all off (8'hFF when SEG_ACTIVE_LOW)
  - digit_sel = none enabled (4'hF when DIG_ACTIVE_LOW)
- First sample is taken on the first cycle after rst deasserts (upd_cnt==0).
- Latency: sample at cycle S; CONVERT occupies S+1..S+14; LOAD at S+15. bcd and bcd_valid are visible in cycle S+16, with bcd_valid high for that cycle only.
- Next sample at S+UPDATE_DIV; no overlap because UPDATE_DIV ≥ 32.
- Display outputs lag bcd/index by one register stage.
  - First cycle after reset: units digit shows "0".
  - A new bcd appears on the display within 1 cycle at the current digit.
- rst mid-conversion: abort, no bcd_valid pulse, all state returns to reset values on that edge.
- speed_in is sampled only on the sample cycle; changes at other times are ignored.

## Test plan
- Reset, CLK_HZ=1000, UPDATE_HZ=10, SCAN_HZ=250, speed_in=1234:
  - bcd=16'h1234 with bcd_valid pulse exactly 16 cycles after the first post-reset cycle
  - scan shows digits 4,3,2,1 in index order 0..3, 4 cycles each
- speed_in=16383, then 10000:
  - bcd=16'h9999 both times
  - seg for every digit = ~6F (active-low)
- speed_in=0:
  - bcd=16'h0000
  - units shows ~3F
  - digits 1–3 seg=8'hFF while digit_sel enables them
- speed_in=7, then 305:
  - first: only units lit (~07)
  - second: hundreds=3, tens=0 lit (~3F), thousands blank
- Assert rst for 1 cycle at cycle S+8 of a conversion of 4321:
  - no bcd_valid
  - bcd stays 0
  - outputs at reset values
  - new sample on the next cycle completes normally 16 cycles later
- Change speed_in every cycle between samples:
  - bcd reflects only the value present on the sample cycle
  - exactly one bcd_valid per UPDATE_DIV cycles
